// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle between a requesting controller and the
// bit-serial add/subtract unit.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one shared full adder, one bit per clock,
// LSB first, with a start/busy/done handshake.
module fullAdder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Result LSB is shifted out before it is ever read, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             c_msb;
  logic             cout_r;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_next;
  logic             last;

  fullAdder u_fa (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .cin (carry),
    .s   (fa_sum),
    .cout(fa_cout)
  );

  assign s_next = {fa_sum, s_sh};
  assign last   = (cnt == CW'(WIDTH - 1));

  // c_msb and cout_r load on the same final edge, so their xor holds with sum.
  assign bus.cout     = cout_r;
  assign bus.overflow = cout_r ^ c_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      c_msb    <= 1'b0;
      cout_r   <= 1'b0;
      bus.sum  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          bus.done <= 1'b0;
        end
        RUN: begin
          s_sh  <= s_next[WIDTH-1:1];
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            c_msb    <= carry;
            cout_r   <= fa_cout;
            bus.sum  <= s_next;
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed vectors push
// expected results; a negedge monitor pops and compares on every done pulse.
module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.s));
        chk("cout", 32'(bus.cout), 32'(e.c));
        chk("overflow", 32'(bus.overflow), 32'(e.o));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum"}, 32'(bus.sum), 32'd0);
    chk({tag, "_cout"}, 32'(bus.cout), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo);
    int busy_cnt;
    bit seen;
    sb.push_back('{s: es, c: ec, o: eo});
    bus.a = ta;
    bus.b = tbv;
    bus.sub = ts;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.a = 8'h5A;
    bus.b = 8'hC3;
    busy_cnt = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'd8);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int t2;
    int n;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;

    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Reset mid-RUN: outputs clear without a clock edge, no done follows.
    bus.a = 8'h55;
    bus.b = 8'h11;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

    // start during RUN is ignored; operands may change after acceptance.
    sb.push_back('{s: 8'h30, c: 1'b0, o: 1'b0});
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.sub = 1'b1;
        bus.start = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin
        n = i;
        break;
      end
    end
    chk("ignored_start_done_at", 32'(n), 32'd9);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n++;
    end
    chk("ignored_start_no_second_op", 32'(n), 32'd0);

    // Back-to-back with start held high.
    sb.push_back('{s: 8'h03, c: 1'b0, o: 1'b0});
    sb.push_back('{s: 8'h07, c: 1'b0, o: 1'b0});
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.a = 8'h03;
    bus.b = 8'h04;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("b2b_busy_vs_done", 32'(bus.busy), 32'(!bus.done));
      if (t1 != 0 && i == t1 + 1) bus.start = 1'b0;
      if (t1 != 0 && i == t1 + 4) chk("sum_held_during_run", 32'(bus.sum), 32'h03);
      if (bus.done) begin
        if (t1 == 0) t1 = i;
        else begin
          t2 = i;
          break;
        end
      end
    end
    chk("b2b_first_done", 32'(t1), 32'd9);
    chk("b2b_spacing", 32'(t2 - t1), 32'd9);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_b2b", 32'(bus.busy), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
